// File: rtl/sisc_ifetch_if.sv
// rtl/sisc_ifetch_if.sv - fetch unit bus bundle: instruction memory port, IR stream, redirect, halt
interface sisc_ifetch_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_data;
  logic [31:0]       ir;
  logic              ir_valid;
  logic              ir_ready;
  logic [ADDR_W-1:0] ir_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic              halted;

  modport master (
    output imem_req, imem_addr, ir, ir_valid, ir_pc, halted,
    input  imem_ack, imem_data, ir_ready, br_taken, br_addr
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid, ir_pc, halted,
    output imem_ack, imem_data, ir_ready, br_taken, br_addr
  );
endinterface

// File: rtl/sisc_ifetch.sv
// rtl/sisc_ifetch.sv - instruction fetch unit with prefetch buffer, branch redirect and HLT stop
// Optional IFETCH_PERF_EN adds saturating fetch/flush counters.
module sisc_ifetch #(
  parameter int                ADDR_W    = 16,
  parameter int                BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  sisc_ifetch_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [15:0]   flush_cnt
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, req_addr;
  logic              halting, halting_n;

  logic [31:0]       buf_data [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc   [BUF_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_n;
  logic [PW:0]       count, count_n;
  logic [31:0]       ir, head_data;
  logic [ADDR_W-1:0] ir_pc, head_pc;

  logic req, push, pop, flush, hlt, br, acked, transfer;

  assign transfer = (count != '0) && bus.ir_ready;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    halting_n = halting;
    req       = 1'b0;
    push      = 1'b0;
    acked     = 1'b0;
    flush     = 1'b0;
    pop       = transfer;
    hlt       = transfer && (ir[31:28] == 4'hF);
    br        = bus.br_taken && !halting && (state != HALT) && !hlt;

    case (state)
      FETCH: begin
        if (count != DEPTH_W) begin
          req     = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          acked   = 1'b1;
          push    = 1'b1;
          pc_n    = pc + ADDR_W'(1);
          state_n = FETCH;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          acked   = 1'b1;
          state_n = halting ? HALT : FETCH;
        end
      end
      default: ;
    endcase

    // A request still in flight after a flush must complete before we move on.
    if (hlt || br) begin
      flush = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      if (br)  pc_n      = bus.br_addr;
      if (hlt) halting_n = 1'b1;
      if (req && !acked) state_n = DRAIN;
      else if (hlt)      state_n = HALT;
      else               state_n = FETCH;
    end
  end

  always_comb begin
    count_n = count + (PW+1)'(push) - (PW+1)'(pop);
    rd_n    = rd_ptr + PW'(pop);
    if ((count - (PW+1)'(pop)) == '0) begin
      head_data = bus.imem_data;
      head_pc   = pc;
    end else begin
      head_data = buf_data[rd_n];
      head_pc   = buf_pc[rd_n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_addr <= '0;
      halting  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ir       <= '0;
      ir_pc    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      halting <= halting_n;
      if (state == FETCH && req) req_addr <= pc;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        rd_ptr <= rd_n;
        count  <= count_n;
        if (count_n != '0) begin
          ir    <= head_data;
          ir_pc <= head_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      buf_data[wr_ptr] <= bus.imem_data;
      buf_pc[wr_ptr]   <= pc;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (acked && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
      if (br && flush_cnt != '1)    flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

  assign bus.imem_req  = req && !rst;
  assign bus.imem_addr = (state == FETCH) ? pc : req_addr;
  assign bus.ir        = ir;
  assign bus.ir_pc     = ir_pc;
  assign bus.ir_valid  = (count != '0);
  assign bus.halted    = (state == HALT);
endmodule

// File: tb/tb_sisc_ifetch.sv
// tb/tb_sisc_ifetch.sv - directed bench for sisc_ifetch: reset, stream, backpressure, branch, halt, wrap
module tb_sisc_ifetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sisc_ifetch_if #(.ADDR_W(16)) bus ();
  sisc_ifetch_if #(.ADDR_W(4))  wbus ();

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, fetch_cnt_w;
  logic [15:0] flush_cnt, flush_cnt_w;
`endif

  sisc_ifetch #(.ADDR_W(16), .BUF_DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  sisc_ifetch #(.ADDR_W(4), .BUF_DEPTH(2), .RESET_PC(4'hF)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (wbus.master)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt_w),
    .flush_cnt (flush_cnt_w)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem [128];
  int          lat   = 1;
  int          mcnt  = 0;
  int          n_ack = 0;
  logic [15:0] ack_addr_q [$];
  logic [31:0] q_ir [$];
  logic [15:0] q_pc [$];

  int          wcnt = 0;
  int          w_n  = 0;
  logic [3:0]  w_pc [2];
  logic [31:0] w_ir [2];

  // Memory model: ack after lat cycles of held request, one cycle wide.
  always @(negedge clk) begin
    if (rst) begin
      bus.imem_ack = 1'b0;
      ack_addr_q.delete();
    end else if (bus.imem_ack) begin
      bus.imem_ack = 1'b0;
      mcnt = 0;
    end
    if (!bus.imem_req) mcnt = 0;
    else begin
      if (mcnt == lat) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem[bus.imem_addr[6:0]];
        n_ack++;
        ack_addr_q.push_back(bus.imem_addr);
      end
      mcnt++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q_ir.delete();
      q_pc.delete();
    end else if (bus.ir_valid && bus.ir_ready) begin
      q_ir.push_back(bus.ir);
      q_pc.push_back(bus.ir_pc);
    end
  end

  always @(negedge clk) begin
    if (rst || wbus.imem_ack) begin
      wbus.imem_ack = 1'b0;
      wcnt = 0;
    end
    if (!wbus.imem_req) wcnt = 0;
    else begin
      if (wcnt == 1) begin
        wbus.imem_ack  = 1'b1;
        wbus.imem_data = 32'h0012_3000 | {28'h0, wbus.imem_addr};
      end
      wcnt++;
    end
  end

  always @(negedge clk) begin
    if (rst) w_n = 0;
    else if (wbus.ir_valid && wbus.ir_ready && w_n < 2) begin
      w_pc[w_n] = wbus.ir_pc;
      w_ir[w_n] = wbus.ir;
      w_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.ir_ready = 1'b0;
    bus.br_taken = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int k = 0;
    while (q_ir.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("q_fill", q_ir.size(), n);
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 128; i++) mem[i] = (i == 0) ? 32'h0 : (32'h8012_3000 | i);
    bus.ir_ready  = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_addr   = '0;
    wbus.ir_ready = 1'b1;
    wbus.br_taken = 1'b0;
    wbus.br_addr  = '0;

    // reset
    repeat (2) tick();
    check("rst_req",      bus.imem_req, 1'b0);
    check("rst_valid",    bus.ir_valid, 1'b0);
    check("rst_halted",   bus.halted,   1'b0);
    check("rst_ir",       bus.ir,       32'h0);
    check("rst_ir_pc",    bus.ir_pc,    16'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("first_req",    bus.imem_req,  1'b1);
    check("first_addr",   bus.imem_addr, 16'h0000);

    // stream
    do_reset();
    bus.ir_ready = 1'b1;
    wait_q(4, 100);
    check("s_ir0", q_ir[0], 32'h0000_0000);
    check("s_ir1", q_ir[1], 32'h8012_3001);
    check("s_ir2", q_ir[2], 32'h8012_3002);
    check("s_ir3", q_ir[3], 32'h8012_3003);
    check("s_pc0", q_pc[0], 16'h0000);
    check("s_pc1", q_pc[1], 16'h0001);
    check("s_pc2", q_pc[2], 16'h0002);
    check("s_pc3", q_pc[3], 16'h0003);

    // backpressure
    do_reset();
    a0 = n_ack;
    repeat (20) tick();
    check("bp_acks",  n_ack - a0,    2);
    check("bp_req",   bus.imem_req,  1'b0);
    check("bp_valid", bus.ir_valid,  1'b1);
    check("bp_ir",    bus.ir,        32'h0000_0000);
    check("bp_pc",    bus.ir_pc,     16'h0000);
    check("bp_none",  q_ir.size(),   0);
    bus.ir_ready = 1'b1;
    wait_q(3, 100);
    check("bp_ir0", q_ir[0], 32'h0000_0000);
    check("bp_ir1", q_ir[1], 32'h8012_3001);
    check("bp_ir2", q_ir[2], 32'h8012_3002);
    check("bp_pc2", q_pc[2], 16'h0002);

    // branch during WAIT with 3-cycle ack
    lat = 3;
    do_reset();
    bus.ir_ready = 1'b1;
    tick();
    bus.br_taken = 1'b1;
    bus.br_addr  = 16'h0040;
    tick();
    bus.br_taken = 1'b0;
    @(negedge clk); #1;
    check("br_drain_req",  bus.imem_req,  1'b1);
    check("br_drain_addr", bus.imem_addr, 16'h0000);
    check("br_valid",      bus.ir_valid,  1'b0);
    wait_q(1, 100);
    check("br_pc",    q_pc[0],       16'h0040);
    check("br_ir",    q_ir[0],       32'h8012_3040);
    check("br_ack0",  ack_addr_q[0], 16'h0000);
    check("br_ack1",  ack_addr_q[1], 16'h0040);

    // halt
    lat    = 1;
    mem[5] = 32'hF023_0000;
    do_reset();
    bus.ir_ready = 1'b1;
    for (int k = 0; k < 200 && !bus.halted; k++) tick();
    check("h_halted", bus.halted,  1'b1);
    check("h_count",  q_ir.size(), 6);
    check("h_ir",     q_ir[5],     32'hF023_0000);
    check("h_pc",     q_pc[5],     16'h0005);
    a0 = n_ack;
    bus.br_taken = 1'b1;
    bus.br_addr  = 16'h0010;
    tick();
    bus.br_taken = 1'b0;
    repeat (10) tick();
    check("h_no_ack",   n_ack - a0,   0);
    check("h_req",      bus.imem_req, 1'b0);
    check("h_valid",    bus.ir_valid, 1'b0);
    check("h_still",    bus.halted,   1'b1);
    check("h_no_xfer",  q_ir.size(),  6);

    // wrap instance (ADDR_W=4, RESET_PC=15), running since the last reset
    check("w_n",   w_n,     2);
    check("w_pc0", w_pc[0], 4'hF);
    check("w_pc1", w_pc[1], 4'h0);
    check("w_ir0", w_ir[0], 32'h0012_300F);
    check("w_ir1", w_ir[1], 32'h0012_3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
